// File: rtl/rv64_trap_ctrl.sv
// rv64_trap_ctrl: machine-mode trap entry / MRET sequencer.
// Writes mepc, mcause and mtval, then mstatus, through the CSR file's hardware
// write ports. It then issues a PC redirect to mtvec (trap) or mepc (MRET).
// Optional macro TRAP_VECTORED_EN: vectored mtvec mode for the timer interrupt.
//
// state      | meaning
// IDLE       | waiting for a request, trap_ready high
// ENTER_SAVE | writing mepc, mcause, mtval
// ENTER_STAT | writing mstatus for trap entry, computing mtvec target
// RET_STAT   | writing mstatus for MRET, capturing mepc target
// REDIRECT   | holding redirect until fetch accepts it
module rv64_trap_ctrl #(
  parameter int         XLEN    = 64,
  parameter logic [1:0] MPP_VAL = 2'b11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  output logic            trap_ready,
  input  logic [2:0]      trap_kind,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic [XLEN-1:0] csr_mstatus_rdata,
  input  logic [XLEN-1:0] csr_mepc_rdata,
  input  logic [XLEN-1:0] csr_mtvec_rdata,
  output logic [XLEN-1:0] csr_mstatus_wdata,
  output logic [XLEN-1:0] csr_mepc_wdata,
  output logic [XLEN-1:0] csr_mcause_wdata,
  output logic [XLEN-1:0] csr_mtval_wdata,
  output logic            csr_mstatus_wen,
  output logic            csr_mepc_wen,
  output logic            csr_mcause_wen,
  output logic            csr_mtval_wen,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTER_SAVE, S_ENTER_STAT, S_RET_STAT, S_REDIRECT
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          r_state;
  logic [XLEN-1:0] w_mcause;
  logic [XLEN-1:0] w_mtval;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_target;
  logic            w_is_mret;

`ifdef TRAP_VECTORED_EN
  logic r_is_irq;
`endif

  // Entry mstatus: save MIE into MPIE, disable interrupts, force MPP.
  function automatic logic [XLEN-1:0] f_mstatus_enter(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = MPP_VAL;
    return r;
  endfunction

  // Return mstatus: restore MIE from MPIE, set MPIE, force MPP.
  function automatic logic [XLEN-1:0] f_mstatus_ret(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = MPP_VAL;
    return r;
  endfunction

  // Cause/tval decode straight from the request; captured on accept.
  always_comb begin
    w_is_mret = (trap_kind == 3'b011);
    w_mcause  = XLEN'(2);
    w_mtval   = trap_tval;
    case (trap_kind)
      3'b000: begin w_mcause = XLEN'(11); w_mtval = '0; end
      3'b001: w_mcause = XLEN'(3);
      3'b100: begin w_mcause = {1'b1, {(XLEN-4){1'b0}}, 3'd7}; w_mtval = '0; end
      default: ;
    endcase
  end

  // Redirect target for trap entry; vectored offset only for the timer interrupt.
  always_comb begin
    w_base   = csr_mtvec_rdata & ALIGN_MASK;
    w_target = w_base;
`ifdef TRAP_VECTORED_EN
    if (csr_mtvec_rdata[1:0] == 2'b01 && r_is_irq)
      w_target = w_base + XLEN'(28);
`endif
  end

  // Sequencer with registered outputs; write strobes last exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= S_IDLE;
      trap_ready        <= 1'b1;
      busy              <= 1'b0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      csr_mstatus_wen   <= 1'b0;
      csr_mepc_wen      <= 1'b0;
      csr_mcause_wen    <= 1'b0;
      csr_mtval_wen     <= 1'b0;
      csr_mstatus_wdata <= '0;
      csr_mepc_wdata    <= '0;
      csr_mcause_wdata  <= '0;
      csr_mtval_wdata   <= '0;
`ifdef TRAP_VECTORED_EN
      r_is_irq          <= 1'b0;
`endif
    end else begin
      csr_mstatus_wen   <= 1'b0;
      csr_mepc_wen      <= 1'b0;
      csr_mcause_wen    <= 1'b0;
      csr_mtval_wen     <= 1'b0;
      csr_mstatus_wdata <= '0;
      csr_mepc_wdata    <= '0;
      csr_mcause_wdata  <= '0;
      csr_mtval_wdata   <= '0;
      case (r_state)
        S_IDLE: begin
          if (trap_valid) begin
            trap_ready <= 1'b0;
            busy       <= 1'b1;
`ifdef TRAP_VECTORED_EN
            r_is_irq   <= (trap_kind == 3'b100);
`endif
            if (w_is_mret) begin
              r_state           <= S_RET_STAT;
              csr_mstatus_wen   <= 1'b1;
              csr_mstatus_wdata <= f_mstatus_ret(csr_mstatus_rdata);
            end else begin
              r_state          <= S_ENTER_SAVE;
              csr_mepc_wen     <= 1'b1;
              csr_mcause_wen   <= 1'b1;
              csr_mtval_wen    <= 1'b1;
              csr_mepc_wdata   <= trap_pc & ALIGN_MASK;
              csr_mcause_wdata <= w_mcause;
              csr_mtval_wdata  <= w_mtval;
            end
          end
        end
        S_ENTER_SAVE: begin
          r_state           <= S_ENTER_STAT;
          csr_mstatus_wen   <= 1'b1;
          csr_mstatus_wdata <= f_mstatus_enter(csr_mstatus_rdata);
        end
        S_ENTER_STAT: begin
          r_state        <= S_REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= w_target;
        end
        S_RET_STAT: begin
          r_state        <= S_REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= csr_mepc_rdata;
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            r_state        <= S_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            busy           <= 1'b0;
            trap_ready     <= 1'b1;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
          trap_ready     <= 1'b1;
        end
      endcase
    end
  end

endmodule
